sdram_frame_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single SDRAM controller slave between the camera frame writer (port 0) and the VGA frame reader (port 1) of the D8M video pipeline. It grants in round-robin order with a bounded run length, so neither stream starves. It also tracks outstanding reads in a tag FIFO, so pipelined read data returns to the port that issued it. It sits between the video DMA masters and the SDRAM controller inside the Qsys system.

---
 rtl/sdram_frame_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// rtl/sdram_frame_arbiter.sv - round-robin two-port Avalon-MM arbiter with read-return tag FIFO
// Optional per-port accept counters when SDRAM_ARB_STATS_EN is defined.
module sdram_frame_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_RUN  = 8,
  parameter int MAX_PEND = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  input  logic                s_waitrequest,
  input  logic                s_readdatavalid,
  input  logic [DATA_W-1:0]   s_readdata
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_acc0,
  output logic [31:0]         stat_acc1
`endif
);

  localparam int RUN_W = $clog2(MAX_RUN) + 1;
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t            state_q;
  logic              last_q;
  logic [RUN_W-1:0]  run_q;
  logic              tag_q [MAX_PEND];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic req0, req1, granted, gsel, g_read, g_write;
  logic cmd_wr, cmd_rd, fifo_full, pop, push, rd_stall, accept;
  logic cur_req, oth_req, run_last, pop_tag;

  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    granted   = (state_q != IDLE);
    gsel      = (state_q == GNT1);
    g_read    = gsel ? m1_read  : m0_read;
    g_write   = gsel ? m1_write : m0_write;
    // A simultaneous read+write is treated as a write only.
    cmd_wr    = granted & g_write;
    cmd_rd    = granted & g_read & ~g_write;
    fifo_full = (cnt_q == CNT_W'(MAX_PEND));
    pop       = s_readdatavalid & (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO need not stall then.
    rd_stall  = cmd_rd & fifo_full & ~pop;
    accept    = (cmd_wr | (cmd_rd & ~rd_stall)) & ~s_waitrequest;
    push      = accept & cmd_rd;
    cur_req   = gsel ? req1 : req0;
    oth_req   = gsel ? req0 : req1;
    run_last  = accept & (run_q == RUN_W'(MAX_RUN - 1));
    pop_tag   = tag_q[rd_q];
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign s_write        = cmd_wr;
  assign s_read         = cmd_rd & ~rd_stall;
  assign s_address      = gsel ? m1_address    : m0_address;
  assign s_writedata    = gsel ? m1_writedata  : m0_writedata;
  assign s_byteenable   = gsel ? m1_byteenable : m0_byteenable;
  assign m0_waitrequest = (state_q != GNT0) | s_waitrequest | rd_stall;
  assign m1_waitrequest = (state_q != GNT1) | s_waitrequest | rd_stall;
  assign m0_readdata    = s_readdata;
  assign m1_readdata    = s_readdata;
  assign m0_readdatavalid = pop & ~pop_tag;
  assign m1_readdatavalid = pop &  pop_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      run_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          run_q <= '0;
          if (req0 & (~req1 | last_q)) state_q <= GNT0;
          else if (req1)               state_q <= GNT1;
        end
        default: begin
          if (~cur_req | (run_last & oth_req)) begin
            state_q <= oth_req ? (gsel ? GNT0 : GNT1) : IDLE;
            last_q  <= gsel;
            run_q   <= '0;
          end else if (accept) begin
            run_q <= run_last ? '0 : run_q + RUN_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_q] <= gsel;
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] stat0_q, stat1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else if (accept) begin
      if (gsel) stat1_q <= stat1_q + 32'd1;
      else      stat0_q <= stat0_q + 32'd1;
    end
  end

  assign stat_acc0 = stat0_q;
  assign stat_acc1 = stat1_q;
`endif

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb/tb_sdram_frame_arbiter.sv - vector-table and sequence bench for sdram_frame_arbiter
module tb_sdram_frame_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address, m1_address, s_address;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]    m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0]   stat_acc0, stat_acc1;
`endif

  sdram_frame_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
`ifdef SDRAM_ARB_STATS_EN
    , .stat_acc0(stat_acc0), .stat_acc1(stat_acc1)
`endif
  );

  typedef struct {
    logic m0r, m0w; logic [7:0] a0;
    logic m1r, m1w; logic [7:0] a1;
    logic sw, srv;
    logic er, ew, ep; logic [7:0] ea;
    logic ew0, ew1, ev0, ev1;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0,
                       input logic r1, input logic w1, input logic [7:0] a1,
                       input logic sw, input logic srv);
    m0_read = r0; m0_write = w0; m0_address = AW'(a0);
    m0_writedata = 16'hA000 | DW'(a0); m0_byteenable = 2'b01;
    m1_read = r1; m1_write = w1; m1_address = AW'(a1);
    m1_writedata = 16'hB000 | DW'(a1); m1_byteenable = 2'b10;
    s_waitrequest = sw; s_readdatavalid = srv;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc();
    reset = 1'b0;
  endtask

  task automatic add(input logic m0r, input logic m0w, input logic [7:0] a0,
                     input logic m1r, input logic m1w, input logic [7:0] a1,
                     input logic sw, input logic srv,
                     input logic er, input logic ew, input logic ep, input logic [7:0] ea,
                     input logic ew0, input logic ew1, input logic ev0, input logic ev1);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.a0 = a0; v.m1r = m1r; v.m1w = m1w; v.a1 = a1;
    v.sw = sw; v.srv = srv; v.er = er; v.ew = ew; v.ep = ep; v.ea = ea;
    v.ew0 = ew0; v.ew1 = ew1; v.ev0 = ev0; v.ev1 = ev1;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a stray readdatavalid that must be dropped.
    reset = 1'b1;
    drive(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
    s_readdata = 16'h0000;
    @(negedge clk);
    chk("rst_s_read", 32'(s_read), 0);
    chk("rst_s_write", 32'(s_write), 0);
    chk("rst_m0_wait", 32'(m0_waitrequest), 1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 1);
    chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    do_reset();

    //   m0r m0w a0     m1r m1w a1     sw srv  er ew ep ea     w0 w1 v0 v1
    add(0, 1, 8'h10,  0, 0, 8'h00,  0, 0,   0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 8'h10,  0, 0, 8'h00,  0, 0,   0, 1, 0, 8'h10, 0, 1, 0, 0);
    add(0, 1, 8'h11,  0, 0, 8'h00,  0, 0,   0, 1, 0, 8'h11, 0, 1, 0, 0);
    add(0, 1, 8'h12,  0, 0, 8'h00,  1, 0,   0, 1, 0, 8'h12, 1, 1, 0, 0);
    add(0, 1, 8'h12,  0, 0, 8'h00,  0, 0,   0, 1, 0, 8'h12, 0, 1, 0, 0);
    add(0, 1, 8'h13,  0, 0, 8'h00,  0, 0,   0, 1, 0, 8'h13, 0, 1, 0, 0);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 0,   0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 0,   0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 8'h00,  1, 0, 8'h20,  0, 0,   0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 8'h00,  1, 0, 8'h20,  0, 0,   1, 0, 1, 8'h20, 1, 0, 0, 0);
    add(0, 0, 8'h00,  1, 0, 8'h21,  0, 0,   1, 0, 1, 8'h21, 1, 0, 0, 0);
    add(1, 0, 8'h30,  1, 0, 8'h22,  0, 0,   1, 0, 1, 8'h22, 1, 0, 0, 0);
    add(1, 0, 8'h30,  0, 0, 8'h00,  0, 0,   0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 8'h30,  0, 0, 8'h00,  0, 0,   1, 0, 0, 8'h30, 0, 1, 0, 0);
    add(1, 0, 8'h31,  0, 0, 8'h00,  0, 1,   1, 0, 0, 8'h31, 0, 1, 0, 1);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 1,   0, 0, 0, 8'h00, 0, 1, 0, 1);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 1,   0, 0, 0, 8'h00, 1, 1, 0, 1);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 1,   0, 0, 0, 8'h00, 1, 1, 1, 0);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 1,   0, 0, 0, 8'h00, 1, 1, 1, 0);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 1,   0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(1, 1, 8'h40,  0, 0, 8'h00,  0, 0,   0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(1, 1, 8'h40,  0, 0, 8'h00,  0, 0,   0, 1, 0, 8'h40, 0, 1, 0, 0);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 0,   0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00,  0, 0, 8'h00,  0, 1,   0, 0, 0, 8'h00, 1, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].m0r, tbl[i].m0w, tbl[i].a0, tbl[i].m1r, tbl[i].m1w, tbl[i].a1,
            tbl[i].sw, tbl[i].srv);
      s_readdata = 16'h5A00 | DW'(i);
      @(negedge clk);
      chk($sformatf("v%0d_s_read", i), 32'(s_read), 32'(tbl[i].er));
      chk($sformatf("v%0d_s_write", i), 32'(s_write), 32'(tbl[i].ew));
      chk($sformatf("v%0d_m0_wait", i), 32'(m0_waitrequest), 32'(tbl[i].ew0));
      chk($sformatf("v%0d_m1_wait", i), 32'(m1_waitrequest), 32'(tbl[i].ew1));
      chk($sformatf("v%0d_m0_rdv", i), 32'(m0_readdatavalid), 32'(tbl[i].ev0));
      chk($sformatf("v%0d_m1_rdv", i), 32'(m1_readdatavalid), 32'(tbl[i].ev1));
      if (tbl[i].er || tbl[i].ew) begin
        chk($sformatf("v%0d_s_addr", i), 32'(s_address), 32'(tbl[i].ea));
        chk($sformatf("v%0d_s_be", i), 32'(s_byteenable), tbl[i].ep ? 32'h2 : 32'h1);
      end
      if (tbl[i].ew)
        chk($sformatf("v%0d_s_wdata", i), 32'(s_writedata),
            32'((tbl[i].ep ? 16'hB000 : 16'hA000) | DW'(tbl[i].ea)));
      if (tbl[i].srv) begin
        chk($sformatf("v%0d_m0_rdata", i), 32'(m0_readdata), 32'(16'h5A00 | DW'(i)));
        chk($sformatf("v%0d_m1_rdata", i), 32'(m1_readdata), 32'(16'h5A00 | DW'(i)));
      end
      cyc();
    end

    // Contention: both stream writes; grants alternate every 8 accepts, no idle gap.
    do_reset();
    drive(0, 1, 8'h01, 0, 1, 8'h02, 0, 0);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("cont_idle_write", 32'(s_write), 0);
      end else begin
        chk($sformatf("cont_c%0d_write", c), 32'(s_write), 1);
        chk($sformatf("cont_c%0d_port", c), 32'(s_byteenable),
            (((c - 1) / 8) % 2 == 1) ? 32'h2 : 32'h1);
        chk($sformatf("cont_c%0d_wait", c), 32'({m0_waitrequest, m1_waitrequest}),
            (((c - 1) / 8) % 2 == 1) ? 32'h2 : 32'h1);
      end
      cyc();
    end

    // FIFO full: 8 reads outstanding, 9th stalls until a return frees a slot.
    do_reset();
    drive(1, 0, 8'h50, 0, 0, 8'h00, 0, 0);
    cyc();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("full_acc%0d", c), 32'({s_read, m0_waitrequest}), 32'h2);
      cyc();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("full_stall_s_read", 32'(s_read), 0);
      chk("full_stall_wait", 32'(m0_waitrequest), 1);
      cyc();
    end
    s_readdatavalid = 1'b1;
    @(negedge clk);
    chk("full_pushpop_s_read", 32'(s_read), 1);
    chk("full_pushpop_wait", 32'(m0_waitrequest), 0);
    chk("full_pushpop_rdv", 32'(m0_readdatavalid), 1);
    cyc();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("full_again_s_read", 32'(s_read), 0);
    cyc();

    // Reset with 3 reads pending: grant and FIFO cleared, late return dropped.
    do_reset();
    drive(0, 0, 8'h00, 1, 0, 8'h60, 0, 0);
    for (int c = 0; c < 4; c++) cyc();
    drive(0, 1, 8'h70, 0, 0, 8'h00, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_s_write", 32'(s_write), 0);
    chk("mrst_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'h3);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_idle_write", 32'(s_write), 0);
    cyc();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("mrst_late_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    cyc();

`ifdef SDRAM_ARB_STATS_EN
    do_reset();
    drive(0, 1, 8'h80, 0, 0, 8'h00, 0, 0);
    for (int c = 0; c < 11; c++) cyc();
    drive(0, 0, 8'h00, 1, 0, 8'h90, 0, 0);
    for (int c = 0; c < 7; c++) cyc();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc();
    @(negedge clk);
    chk("stat_acc0", stat_acc0, 32'd10);
    chk("stat_acc1", stat_acc1, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
